// File: rtl/histogram_accumulator_pkg.sv
// Shared constants and types for the histogram accumulator slice.
package histogram_pkg;

   localparam int unsigned PIX_W_DEF   = 8;
   localparam int unsigned COUNT_W_DEF = 16;
   localparam int unsigned BINS_DEF    = 256;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } hist_state_t;

   typedef logic [COUNT_W_DEF-1:0] bin_t;

endpackage

// File: rtl/histogram_bin_incr.sv
// Single-bin incrementer; HISTOGRAM_SATURATE_EN selects clamp-at-max instead of wrap.
module histogram_bin_incr
   import histogram_pkg::*;
#(
   parameter int unsigned COUNT_W = COUNT_W_DEF
) (
   input  logic [COUNT_W-1:0] bin_in,
   output logic [COUNT_W-1:0] bin_out,
   output logic               sat
);

`ifdef HISTOGRAM_SATURATE_EN
   always_comb begin
      sat     = &bin_in;
      bin_out = sat ? bin_in : bin_in + COUNT_W'(1);
   end
`else
   always_comb begin
      sat     = 1'b0;
      bin_out = bin_in + COUNT_W'(1);
   end
`endif

endmodule

// File: rtl/histogram_accumulator.sv
// Per-frame pixel histogram with double-banked bins and end-of-frame publish.
// Saturating counters and o_overflow are enabled by HISTOGRAM_SATURATE_EN.
module histogram_accumulator
   import histogram_pkg::*;
#(
   parameter int unsigned PIX_W   = PIX_W_DEF,
   parameter int unsigned COUNT_W = COUNT_W_DEF
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_pix_valid,
   input  logic [PIX_W-1:0]               i_pix,
   input  logic                           i_sof,
   input  logic                           i_eof,
   output logic [(2**PIX_W)*COUNT_W-1:0]  o_histogram_flat,
   output logic                           o_hist_valid,
   output logic                           o_busy,
   output logic                           o_frame_err,
   output logic                           o_overflow
);

   localparam int unsigned BINS = 2**PIX_W;

   hist_state_t        state;
   logic [COUNT_W-1:0] working   [BINS];
   logic [COUNT_W-1:0] published [BINS];
   logic               sat_flag;

   logic               accept;
   logic               abort;
   logic               eof_now;
   logic [COUNT_W-1:0] bin_cur;
   logic [COUNT_W-1:0] bin_next;
   logic               sat_hit;
   logic               ovf_next;

   assign accept   = i_pix_valid && (state == ACCUM || i_sof);
   assign abort    = i_pix_valid && (state == ACCUM) && i_sof;
   assign eof_now  = accept && i_eof;
   // An aborting beat restarts the frame, so it counts from an empty bin.
   assign bin_cur  = abort ? '0 : working[i_pix];
   assign ovf_next = (abort ? 1'b0 : sat_flag) | sat_hit;

   histogram_bin_incr #(
      .COUNT_W (COUNT_W)
   ) u_bin_incr (
      .bin_in  (bin_cur),
      .bin_out (bin_next),
      .sat     (sat_hit)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= IDLE;
         sat_flag     <= 1'b0;
         o_hist_valid <= 1'b0;
         o_busy       <= 1'b0;
         o_frame_err  <= 1'b0;
         o_overflow   <= 1'b0;
         for (int unsigned j = 0; j < BINS; j++) begin
            working[j]   <= '0;
            published[j] <= '0;
         end
      end else begin
         o_hist_valid <= eof_now;
         o_frame_err  <= abort;
         if (eof_now) begin
            // Publish the bank as it stands after this beat, then start clean.
            for (int unsigned j = 0; j < BINS; j++) begin
               published[j] <= abort ? '0 : working[j];
               working[j]   <= '0;
            end
            published[i_pix] <= bin_next;
            o_overflow       <= ovf_next;
            sat_flag         <= 1'b0;
            state            <= IDLE;
            o_busy           <= 1'b0;
         end else if (accept) begin
            if (abort) begin
               for (int unsigned j = 0; j < BINS; j++)
                  working[j] <= '0;
            end
            working[i_pix] <= bin_next;
            sat_flag       <= ovf_next;
            state          <= ACCUM;
            o_busy         <= 1'b1;
         end
      end
   end

   for (genvar j = 0; j < BINS; j++) begin : g_flat
      assign o_histogram_flat[COUNT_W*j +: COUNT_W] = published[j];
   end

endmodule

// File: tb/tb_histogram_accumulator.sv
// Directed-vector bench for histogram_accumulator.
module tb_histogram_accumulator;

   localparam int unsigned PIX_W   = 8;
   localparam int unsigned COUNT_W = 16;
   localparam int unsigned BINS    = 256;

   logic                      i_clk = 1'b0;
   logic                      i_rst;
   logic                      i_pix_valid;
   logic [PIX_W-1:0]          i_pix;
   logic                      i_sof;
   logic                      i_eof;
   logic [BINS*COUNT_W-1:0]   o_histogram_flat;
   logic                      o_hist_valid;
   logic                      o_busy;
   logic                      o_frame_err;
   logic                      o_overflow;

   int n_vec = 0;
   int n_err = 0;

   histogram_accumulator #(
      .PIX_W   (PIX_W),
      .COUNT_W (COUNT_W)
   ) dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_pix_valid      (i_pix_valid),
      .i_pix            (i_pix),
      .i_sof            (i_sof),
      .i_eof            (i_eof),
      .o_histogram_flat (o_histogram_flat),
      .o_hist_valid     (o_hist_valid),
      .o_busy           (o_busy),
      .o_frame_err      (o_frame_err),
      .o_overflow       (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] bin(input int unsigned j);
      return 32'(o_histogram_flat[COUNT_W*j +: COUNT_W]);
   endfunction

   function automatic logic [31:0] total();
      logic [31:0] s = '0;
      for (int unsigned j = 0; j < BINS; j++) s += bin(j);
      return s;
   endfunction

   // Present one valid beat, wait for it to be captured, return just after the edge.
   task automatic send(input logic [7:0] p, input logic s, input logic e);
      i_pix_valid = 1'b1;
      i_pix       = p;
      i_sof       = s;
      i_eof       = e;
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      i_pix_valid = 1'b0;
      i_sof       = 1'b0;
      i_eof       = 1'b0;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_rst = 1'b1; i_pix_valid = 1'b0; i_pix = '0; i_sof = 1'b0; i_eof = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      check("rst_total", total(), 0);
      check("rst_valid", 32'(o_hist_valid), 0);
      check("rst_busy",  32'(o_busy), 0);
      check("rst_err",   32'(o_frame_err), 0);
      check("rst_ovf",   32'(o_overflow), 0);
      i_rst = 1'b0;
      idle();

      // Frame 5,5,200
      send(5, 1, 0);
      send(5, 0, 0);
      check("t1_busy_mid", 32'(o_busy), 1);
      send(200, 0, 1);
      check("t1_valid", 32'(o_hist_valid), 1);
      check("t1_bin5",  bin(5), 2);
      check("t1_bin200", bin(200), 1);
      check("t1_total", total(), 3);
      check("t1_busy",  32'(o_busy), 0);
      idle();
      check("t1_pulse_end", 32'(o_hist_valid), 0);
      check("t1_hold5", bin(5), 2);

      // 70000 beats of pixel 0
      send(0, 1, 0);
      repeat (69998) send(0, 0, 0);
      send(0, 0, 1);
      check("t2_valid", 32'(o_hist_valid), 1);
`ifdef HISTOGRAM_SATURATE_EN
      check("t2_bin0", bin(0), 32'hFFFF);
      check("t2_ovf",  32'(o_overflow), 1);
`else
      check("t2_bin0", bin(0), 4464);
      check("t2_ovf",  32'(o_overflow), 0);
`endif
      check("t2_bin5", bin(5), 0);
      idle();

      // Abort mid-frame
      send(7, 1, 0);
      send(7, 0, 0);
      send(7, 0, 0);
      send(9, 1, 0);
      check("t3_err", 32'(o_frame_err), 1);
      check("t3_novalid", 32'(o_hist_valid), 0);
      send(9, 0, 1);
      check("t3_err_end", 32'(o_frame_err), 0);
      check("t3_valid", 32'(o_hist_valid), 1);
      check("t3_bin7", bin(7), 0);
      check("t3_bin9", bin(9), 2);
      check("t3_total", total(), 2);
      check("t3_ovf", 32'(o_overflow), 0);
      idle();

      // Beats ignored in IDLE, then single-beat frame
      repeat (10) send(3, 0, 0);
      check("t4_idle_busy", 32'(o_busy), 0);
      check("t4_idle_valid", 32'(o_hist_valid), 0);
      send(4, 1, 1);
      check("t4_valid", 32'(o_hist_valid), 1);
      check("t4_bin4", bin(4), 1);
      check("t4_bin3", bin(3), 0);
      check("t4_total", total(), 1);
      check("t4_busy", 32'(o_busy), 0);
      idle();

      // Back-to-back frames {1,1},{2}
      send(1, 1, 0);
      check("t5_busy", 32'(o_busy), 1);
      send(1, 0, 1);
      check("t5_valid_a", 32'(o_hist_valid), 1);
      check("t5_bin1_a", bin(1), 2);
      send(2, 1, 1);
      check("t5_valid_b", 32'(o_hist_valid), 1);
      check("t5_bin1_b", bin(1), 0);
      check("t5_bin2_b", bin(2), 1);
      idle();

      // Reset mid-frame
      send(6, 1, 0);
      send(6, 0, 0);
      i_pix_valid = 1'b0; i_sof = 1'b0; i_eof = 1'b0;
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      check("t6_total", total(), 0);
      check("t6_busy", 32'(o_busy), 0);
      check("t6_valid", 32'(o_hist_valid), 0);
      check("t6_err", 32'(o_frame_err), 0);
      check("t6_ovf", 32'(o_overflow), 0);
      send(6, 1, 1);
      check("t6_valid_b", 32'(o_hist_valid), 1);
      check("t6_bin6", bin(6), 1);
      check("t6_total_b", total(), 1);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/histogram_accumulator.md
# histogram_accumulator

- Streaming producer of the 256×16-bit flattened histogram that feeds `histogram_derivative`.
- Consumes one frame of 8-bit pixel samples and counts occurrences per intensity bin.
- At end of frame, publishes a stable histogram snapshot plus a one-cycle valid pulse, then clears for the next frame.
- Sits between the sensor pixel stream and the histogram post-processing (derivative, threshold search) in the star-tracker pipeline.

## Interface
Parameters:
- `PIX_W`, 8, pixel width; bin count `BINS = 2**PIX_W`.
- `COUNT_W`, 16, per-bin counter width.

Ports (one clock; reset is synchronous and active-high):
- `i_clk`  in  1  sole clock; all state updates on rising edge.
- `i_rst`  in  1  synchronous active-high reset.
- `i_pix_valid`  in  1  pixel beat valid.
- `i_pix`  in  PIX_W  pixel intensity, selects bin.
- `i_sof`  in  1  start-of-frame; qualified by `i_pix_valid`.
- `i_eof`  in  1  end-of-frame; qualified by `i_pix_valid`.
- `o_histogram_flat`  out  BINS*COUNT_W  published histogram; bin j at bits `[COUNT_W*j +: COUNT_W]`.
- `o_hist_valid`  out  1  one-cycle pulse, new histogram published.
- `o_busy`  out  1  high while in ACCUM.
- `o_frame_err`  out  1  one-cycle pulse on aborted frame.
- `o_overflow`  out  1  sticky per published frame, any bin saturated.

## Operation
- Two banks:
  - working bins: internal, `BINS` × `COUNT_W`.
  - published bins: drive `o_histogram_flat`.
- FSM states: IDLE, ACCUM.
- IDLE:
  - Beats without `i_sof` are ignored.
  - A beat with `i_sof`: counts `i_pix` into working bin, goes to ACCUM.
- ACCUM:
  - Each valid beat increments `working[i_pix]` by 1.
- EOF (valid beat with `i_eof`, in ACCUM, or in IDLE together with `i_sof`):
  - That beat's pixel is counted.
  - The resulting working bank is copied to the published bank on the same edge.
  - Working bank cleared; `o_hist_valid` pulses; next state is IDLE.
- `i_sof` in ACCUM (no `i_eof`):
  - Abort: working bank cleared, then the sof pixel counted as bin value 1.
  - `o_frame_err` pulses; state stays ACCUM; published bank untouched.
- `i_sof` and `i_eof` on the same beat in ACCUM:
  - Treated as abort followed by single-pixel frame.
  - Publishes a bank with only `bin[i_pix] = 1`.
  - `o_frame_err` and `o_hist_valid` both pulse.
- Inputs with `i_pix_valid` low are ignored entirely.
- Counter arithmetic: unsigned `COUNT_W`; behaviour at all-ones set by Configuration.
- Published bank holds its value until the next EOF or reset.

## Timing
- Reset values:
  - All working and published bins 0.
  - `o_hist_valid` 0, `o_busy` 0, `o_frame_err` 0, `o_overflow` 0.
  - State IDLE.
- Reset mid-frame discards the frame; no publish.
- Latency: EOF beat at edge N → `o_hist_valid` high and new `o_histogram_flat` visible for cycle N+1 only (valid pulse); data persists.
- Back-to-back frames: a sof beat on the cycle right after EOF is accepted; no bubble required.
- Throughput: one pixel per cycle, no backpressure.
- `o_busy` registered: high the cycle after an accepted sof, low the cycle after EOF.
- `o_frame_err` registered, one cycle after the offending beat.

## Configuration
- `HISTOGRAM_SATURATE_EN` defined:
  - Bin increments clamp at `2**COUNT_W-1`.
  - Any clamp attempt in a frame sets an internal flag.
  - The flag is copied to `o_overflow` at publish and cleared with the working bank.
- Not defined:
  - Bins wrap modulo `2**COUNT_W`.
  - `o_overflow` tied 0.

## Structure
- Package `histogram_pkg`:
  - Constants `PIX_W_DEF = 8`, `COUNT_W_DEF = 16`, `BINS_DEF = 256`.
  - Typedef `hist_state_t` enum {IDLE, ACCUM}.
  - Typedef `bin_t` = `logic [COUNT_W_DEF-1:0]`.
- Sub-module `histogram_bin_incr`:
  - Combinational: bin value in, incremented value and saturation flag out.
  - Honours `HISTOGRAM_SATURATE_EN`.
  - Instantiated once, on the bin selected by `i_pix`.

## Test plan
- Frame of pixels 5, 5, 200 (sof on first, eof on last) → one cycle after eof: `o_hist_valid`=1, bin5=2, bin200=1, all others 0, `o_busy` low.
- 70000 beats of pixel 0 in one frame:
  - With `HISTOGRAM_SATURATE_EN` → bin0=0xFFFF, `o_overflow`=1.
  - Without → bin0=4464, `o_overflow`=0.
- Frame 7,7,7 then second sof mid-frame with pixel 9, then 9 with eof → `o_frame_err` pulse, published bin7=0, bin9=2.
- Beats without sof while IDLE (pixel 3 ×10), then sof+eof single beat pixel 4 → published only bin4=1, bin3=0.
- Back-to-back frames {1,1}, {2} with sof on cycle after eof → two `o_hist_valid` pulses; second snapshot bin1=0, bin2=1.
- `i_rst` asserted mid-frame after pixels 6,6 → all outputs 0; next frame {6} publishes bin6=1.
